// File: rtl/usrt_tx_sched.sv
// usrt_tx_sched: round-robin scheduler sharing one txshift serializer between N_REQ byte requesters.
// Optional macro USRT_TXSCHED_LOCK_EN lets a locked requester keep the grant for back-to-back frames.
module usrt_tx_sched #(
    parameter int N_REQ     = 4,
    parameter int DRAIN_CYC = 12
) (
    input  logic                 i_Pclk,
    input  logic                 i_Presetn,
    input  logic [N_REQ-1:0]     i_Req,
    input  logic [8*N_REQ-1:0]   i_Data,
    input  logic [N_REQ-1:0]     i_Lock,
    input  logic [7:0]           i_Baud,
    output logic [N_REQ-1:0]     o_Grant,
    output logic [N_REQ-1:0]     o_Ack,
    output logic                 o_Busy,
    output logic                 o_Tx_Enable,
    output logic [7:0]           o_Tx_Data,
    output logic [7:0]           o_Tx_Baud,
    input  logic                 i_Tx_Pready
);

    // state  | meaning
    // DRAIN  | post-reset flush: baud forced to 1, no enable, Pready ignored
    // IDLE   | not busy; arbitrate and launch on any request
    // LAUNCH | enable pulse is on the shifter input
    // WAIT   | frame in flight, waiting for the shifter's Pready
    // GAP    | ack cycle; keeps the next enable off a shifter still returning to idle
    typedef enum logic [2:0] {
        DRAIN  = 3'd0,
        IDLE   = 3'd1,
        LAUNCH = 3'd2,
        WAIT   = 3'd3,
        GAP    = 3'd4
    } state_t;

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;

    logic [N_REQ-1:0]   grant_d;
    logic [N_REQ-1:0]   ack_d;
    logic               busy_d;
    logic               tx_enable_d;
    logic [7:0]         tx_data_d;
    logic [7:0]         tx_baud_d;

    logic               arb_hit;
    logic [IDX_W-1:0]   arb_idx;
    logic [7:0]         arb_data;
    logic [IDX_W-1:0]   ptr_adv;

    // First requester at or after the pointer, searching upward with wrap.
    always_comb begin : arb_search
        int k;
        k        = 0;
        arb_hit  = 1'b0;
        arb_idx  = '0;
        arb_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = int'(ptr_q) + i;
            if (k >= N_REQ) begin
                k = k - N_REQ;
            end
            if (!arb_hit && i_Req[k]) begin
                arb_hit  = 1'b1;
                arb_idx  = IDX_W'(k);
                arb_data = i_Data[8*k +: 8];
            end
        end
    end

    assign ptr_adv = (win_q == IDX_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;

`ifndef USRT_TXSCHED_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^i_Lock;
`endif

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        grant_d     = o_Grant;
        ack_d       = '0;
        tx_enable_d = 1'b0;
        tx_data_d   = o_Tx_Data;
        tx_baud_d   = o_Tx_Baud;

        case (state_q)
            DRAIN: begin
                tx_baud_d = 8'd1;
                if (drain_cnt_q == CNT_W'(DRAIN_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (arb_hit) begin
                    win_d       = arb_idx;
                    grant_d     = {{(N_REQ-1){1'b0}}, 1'b1} << arb_idx;
                    tx_data_d   = arb_data;
                    // A zero divisor would make the shifter count forever.
                    tx_baud_d   = (i_Baud == 8'd0) ? 8'd1 : i_Baud;
                    tx_enable_d = 1'b1;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (i_Tx_Pready) begin
                    ack_d   = o_Grant;
                    grant_d = '0;
                    ptr_d   = ptr_adv;
                    state_d = GAP;
                end
            end
            GAP: begin
`ifdef USRT_TXSCHED_LOCK_EN
                if (i_Lock[win_q] && i_Req[win_q]) begin
                    ptr_d = win_q;
                end
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = DRAIN;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_Pclk or negedge i_Presetn) begin
        if (!i_Presetn) begin
            state_q     <= DRAIN;
            drain_cnt_q <= '0;
            ptr_q       <= '0;
            win_q       <= '0;
            o_Grant     <= '0;
            o_Ack       <= '0;
            o_Busy      <= 1'b1;
            o_Tx_Enable <= 1'b0;
            o_Tx_Data   <= 8'd0;
            o_Tx_Baud   <= 8'd1;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            o_Grant     <= grant_d;
            o_Ack       <= ack_d;
            o_Busy      <= busy_d;
            o_Tx_Enable <= tx_enable_d;
            o_Tx_Data   <= tx_data_d;
            o_Tx_Baud   <= tx_baud_d;
        end
    end

endmodule

// File: tb/tb_usrt_tx_sched.sv
// tb_usrt_tx_sched: timing-rule model of the scheduler plus a behavioural shifter on the tx side.
module tb_usrt_tx_sched;
    localparam int N_REQ     = 4;
    localparam int DRAIN_CYC = 12;

    logic                 i_Pclk;
    logic                 i_Presetn;
    logic [N_REQ-1:0]     i_Req;
    logic [8*N_REQ-1:0]   i_Data;
    logic [N_REQ-1:0]     i_Lock;
    logic [7:0]           i_Baud;
    logic [N_REQ-1:0]     o_Grant;
    logic [N_REQ-1:0]     o_Ack;
    logic                 o_Busy;
    logic                 o_Tx_Enable;
    logic [7:0]           o_Tx_Data;
    logic [7:0]           o_Tx_Baud;
    logic                 i_Tx_Pready;

    logic sh_pready;
    logic force_pready;
    assign i_Tx_Pready = sh_pready | force_pready;

    usrt_tx_sched #(.N_REQ(N_REQ), .DRAIN_CYC(DRAIN_CYC)) dut (
        .i_Pclk      (i_Pclk),
        .i_Presetn   (i_Presetn),
        .i_Req       (i_Req),
        .i_Data      (i_Data),
        .i_Lock      (i_Lock),
        .i_Baud      (i_Baud),
        .o_Grant     (o_Grant),
        .o_Ack       (o_Ack),
        .o_Busy      (o_Busy),
        .o_Tx_Enable (o_Tx_Enable),
        .o_Tx_Data   (o_Tx_Data),
        .o_Tx_Baud   (o_Tx_Baud),
        .i_Tx_Pready (i_Tx_Pready)
    );

    initial i_Pclk = 1'b0;
    always #5 i_Pclk = ~i_Pclk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model state: edges counted since reset release, owner of the current frame, pointer.
    int         m_e, m_owner, m_launch_e, m_free_e, m_ptr, m_lock_e, m_last, mk;
    logic [7:0] m_data, m_baud;
    logic [N_REQ-1:0] m_ack, m_grant;
    logic       m_en;

    int ack_cnt [N_REQ];
    int glog [$];
    int pready_cyc = -1;
    int min_gap    = 1000;

    task automatic model_reset();
        m_e        = 0;
        m_owner    = -1;
        m_launch_e = 0;
        m_free_e   = DRAIN_CYC + 1;
        m_ptr      = 0;
        m_lock_e   = -1;
        m_last     = 0;
        m_data     = 8'd0;
        m_baud     = 8'd1;
        m_ack      = '0;
        m_en       = 1'b0;
        pready_cyc = -1;
    endtask

    initial begin
        for (int i = 0; i < N_REQ; i++) ack_cnt[i] = 0;
        model_reset();
    end

    always @(posedge i_Pclk) begin
        #1;
        cyc++;
        if (!i_Presetn) begin
            model_reset();
        end else begin
            m_e++;
            m_ack = '0;
            m_en  = 1'b0;
`ifdef USRT_TXSCHED_LOCK_EN
            if (m_e == m_lock_e && i_Lock[m_last] && i_Req[m_last]) m_ptr = m_last;
`endif
            if (m_owner >= 0) begin
                if (m_e >= m_launch_e + 2 && i_Tx_Pready) begin
                    m_ack[m_owner] = 1'b1;
                    m_last   = m_owner;
                    m_ptr    = (m_owner + 1) % N_REQ;
                    m_owner  = -1;
                    m_free_e = m_e + 2;
                    m_lock_e = m_e + 1;
                end
            end else if (m_e >= m_free_e && i_Req != '0) begin
                for (int i = 0; i < N_REQ; i++) begin
                    mk = (m_ptr + i) % N_REQ;
                    if (i_Req[mk]) begin
                        m_owner = mk;
                        break;
                    end
                end
                m_launch_e = m_e;
                m_data     = i_Data[8*m_owner +: 8];
                m_baud     = (i_Baud == 8'd0) ? 8'd1 : i_Baud;
                m_en       = 1'b1;
            end
        end
        m_grant = '0;
        if (m_owner >= 0) m_grant[m_owner] = 1'b1;

        chk("grant",     32'(o_Grant),     32'(m_grant));
        chk("ack",       32'(o_Ack),       32'(m_ack));
        chk("busy",      32'(o_Busy),      32'(!(m_owner < 0 && m_e >= m_free_e - 1)));
        chk("tx_enable", 32'(o_Tx_Enable), 32'(m_en));
        chk("tx_data",   32'(o_Tx_Data),   32'(m_data));
        chk("tx_baud",   32'(o_Tx_Baud),   32'(m_baud));

        for (int i = 0; i < N_REQ; i++) if (o_Ack[i] === 1'b1) ack_cnt[i]++;
        if (o_Ack != '0) pready_cyc = cyc - 1;
        if (o_Tx_Enable === 1'b1) begin
            mk = -1;
            for (int i = 0; i < N_REQ; i++) if (o_Grant[i] === 1'b1) mk = i;
            glog.push_back(mk);
            if (pready_cyc >= 0 && cyc - pready_cyc < min_gap) min_gap = cyc - pready_cyc;
        end
    end

    // Shifter: start, 8 data bits LSB first, stop, each o_Tx_Baud clocks; reads the DUT's
    // data/baud live so any change during the frame shows on the line.
    logic       sh_active, sh_abort;
    int         sh_cnt, sh_bi, sh_bad;
    logic [7:0] sh_data, sh_baud;
    logic [9:0] sh_frame;
    logic       sh_samp [$];

    initial begin
        sh_pready = 1'b0;
        sh_active = 1'b0;
        sh_abort  = 1'b0;
        sh_cnt    = 0;
        forever begin
            @(negedge i_Pclk);
            sh_pready = 1'b0;
            if (!i_Presetn) sh_abort = 1'b1;
            if (sh_active) begin
                sh_bi = sh_cnt / ((o_Tx_Baud == 8'd0) ? 1 : int'(o_Tx_Baud));
                if (sh_bi >= 10) begin
                    sh_pready = 1'b1;
                    sh_active = 1'b0;
                    if (!sh_abort) begin
                        n_cmp++;
                        if (sh_samp.size() != 10 * int'(sh_baud)) begin
                            n_bad++;
                            $display("FAIL line_len: actual %0d clocks required %0d", sh_samp.size(), 10 * int'(sh_baud));
                        end else begin
                            sh_frame = {1'b1, sh_data, 1'b0};
                            sh_bad = -1;
                            for (int i = 0; i < sh_samp.size(); i++)
                                if (sh_bad < 0 && sh_samp[i] !== sh_frame[i / int'(sh_baud)]) sh_bad = i;
                            n_cmp++;
                            if (sh_bad >= 0) begin
                                n_bad++;
                                $display("FAIL line_bits: clock %0d actual %b required %b (byte %h)",
                                         sh_bad, sh_samp[sh_bad], sh_frame[sh_bad / int'(sh_baud)], sh_data);
                            end
                        end
                    end
                end else begin
                    sh_samp.push_back((sh_bi == 0) ? 1'b0 : (sh_bi == 9) ? 1'b1 : o_Tx_Data[sh_bi-1]);
                    sh_cnt++;
                end
            end else if (o_Tx_Enable === 1'b1 && i_Presetn) begin
                sh_active = 1'b1;
                sh_abort  = 1'b0;
                sh_cnt    = 0;
                sh_samp.delete();
                sh_data   = m_data;
                sh_baud   = m_baud;
            end
        end
    end

    task automatic wait_ack(input logic [N_REQ-1:0] mask, input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge i_Pclk);
            n++;
        end while ((o_Ack & mask) == '0 && n < budget);
        n_cmp++;
        if ((o_Ack & mask) == '0) begin
            n_bad++;
            $display("FAIL %s: no ack after %0d cycles, required an ack on %b", name, n, mask);
        end
    endtask

    task automatic wait_enable(input string name);
        int n;
        n = 0;
        do begin
            @(negedge i_Pclk);
            n++;
        end while (o_Tx_Enable !== 1'b1 && n < 100);
        n_cmp++;
        if (o_Tx_Enable !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: enable still %b after %0d cycles, required 1", name, o_Tx_Enable, n);
        end
    endtask

    task automatic wait_idle(input string name, output int n);
        n = 0;
        do begin
            @(negedge i_Pclk);
            n++;
        end while (o_Busy !== 1'b0 && n < 100);
        n_cmp++;
        if (o_Busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: busy still %b after %0d cycles, required 0", name, o_Busy, n);
        end
    endtask

    task automatic pulse_reset();
        int n;
        i_Presetn = 1'b0;
        @(negedge i_Pclk);
        @(negedge i_Pclk);
        i_Presetn = 1'b1;
        wait_idle("reset_drain", n);
    endtask

    int a5_bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int rr_exp  [6]  = '{0, 1, 3, 0, 1, 3};
    int rr_acks [4]  = '{2, 2, 0, 2};
`ifdef USRT_TXSCHED_LOCK_EN
    int lk_exp  [4]  = '{0, 0, 0, 1};
`else
    int lk_exp  [4]  = '{0, 1, 0, 1};
`endif

    initial begin
        int n, gb, s1;
        int snap [N_REQ];
        i_Presetn    = 1'b0;
        i_Req        = '0;
        i_Data       = '0;
        i_Lock       = '0;
        i_Baud       = 8'd0;
        force_pready = 1'b0;
        repeat (3) @(negedge i_Pclk);
        i_Presetn = 1'b1;

        wait_idle("drain", n);
        chk("drain_len", 32'(n), 32'(DRAIN_CYC));
        chk("drain_baud", 32'(o_Tx_Baud), 32'd1);

        // Single frame, byte A5 at baud 4; data/baud changed mid-frame must not leak through.
        i_Data[7:0] = 8'hA5;
        i_Baud      = 8'd4;
        i_Req       = 4'b0001;
        s1 = ack_cnt[0];
        wait_enable("a5_enable");
        chk("a5_grant", 32'(o_Grant), 32'h1);
        chk("a5_tx_data", 32'(o_Tx_Data), 32'hA5);
        repeat (5) @(negedge i_Pclk);
        i_Data[7:0] = 8'h00;
        i_Baud      = 8'd7;
        wait_ack(4'b0001, 200, "a5_ack");
        i_Req = '0;
        repeat (6) @(negedge i_Pclk);
        chk("a5_ack_once", 32'(ack_cnt[0] - s1), 32'd1);
        chk("a5_len", 32'(sh_samp.size()), 32'd40);
        for (int i = 0; i < 10; i++)
            if (4*i + 2 < sh_samp.size()) chk("a5_bit", 32'(sh_samp[4*i + 2]), 32'(a5_bits[i]));

        // Round robin over requesters 0,1,3 from a fresh pointer.
        pulse_reset();
        i_Data = {8'h44, 8'h33, 8'h22, 8'h11};
        i_Baud = 8'd2;
        gb = glog.size();
        for (int i = 0; i < N_REQ; i++) snap[i] = ack_cnt[i];
        i_Req = 4'b1011;
        for (int f = 0; f < 6; f++) begin
            wait_ack(4'b1111, 200, "rr_ack");
            if (f == 5) i_Req = '0;
        end
        repeat (4) @(negedge i_Pclk);
        chk("rr_count", 32'(glog.size() - gb), 32'd6);
        for (int f = 0; f < 6; f++)
            if (gb + f < glog.size()) chk("rr_order", 32'(glog[gb + f]), 32'(rr_exp[f]));
        for (int i = 0; i < N_REQ; i++) chk("rr_acks", 32'(ack_cnt[i] - snap[i]), 32'(rr_acks[i]));
        chk("rr_gap_ge3", 32'(min_gap >= 3), 32'd1);

        // Stray Pready in IDLE and LAUNCH, then baud 0 substituted by 1.
        force_pready = 1'b1;
        @(negedge i_Pclk);
        force_pready = 1'b0;
        i_Data[23:16] = 8'h3C;
        i_Baud        = 8'd0;
        i_Req         = 4'b0100;
        wait_enable("b0_enable");
        force_pready = 1'b1;
        chk("b0_tx_baud", 32'(o_Tx_Baud), 32'd1);
        chk("b0_grant", 32'(o_Grant), 32'h4);
        @(negedge i_Pclk);
        force_pready = 1'b0;
        wait_ack(4'b0100, 100, "b0_ack");
        i_Req = '0;
        repeat (3) @(negedge i_Pclk);

        // Reset during the data bits of a baud-8 frame.
        i_Data[15:8] = 8'h96;
        i_Baud       = 8'd8;
        i_Req        = 4'b0010;
        s1 = ack_cnt[1];
        wait_enable("rst_enable");
        repeat (30) @(negedge i_Pclk);
        i_Presetn = 1'b0;
        i_Req     = '0;
        #1;
        chk("rst_grant", 32'(o_Grant), 32'd0);
        chk("rst_ack", 32'(o_Ack), 32'd0);
        chk("rst_busy", 32'(o_Busy), 32'd1);
        chk("rst_enable", 32'(o_Tx_Enable), 32'd0);
        chk("rst_tx_data", 32'(o_Tx_Data), 32'd0);
        chk("rst_tx_baud", 32'(o_Tx_Baud), 32'd1);
        @(negedge i_Pclk);
        @(negedge i_Pclk);
        i_Presetn = 1'b1;
        wait_idle("rst_drain", n);
        chk("rst_no_ack", 32'(ack_cnt[1] - s1), 32'd0);
        i_Data[15:8] = 8'h5A;
        i_Baud       = 8'd3;
        i_Req        = 4'b0010;
        wait_ack(4'b0010, 200, "rst_new_ack");
        i_Req = '0;
        repeat (3) @(negedge i_Pclk);
        chk("rst_new_acks", 32'(ack_cnt[1] - s1), 32'd1);

        // Lock on requester 0, released on its third ack.
        i_Data[7:0]  = 8'hAA;
        i_Data[15:8] = 8'hBB;
        i_Baud       = 8'd1;
        i_Lock       = 4'b0001;
        gb = glog.size();
        i_Req = 4'b0011;
        for (int f = 0; f < 4; f++) begin
            wait_ack(4'b0011, 100, "lock_ack");
            if (f == 2) i_Lock = '0;
            if (f == 3) i_Req = '0;
        end
        repeat (4) @(negedge i_Pclk);
        chk("lock_count", 32'(glog.size() - gb), 32'd4);
        for (int f = 0; f < 4; f++)
            if (gb + f < glog.size()) chk("lock_order", 32'(glog[gb + f]), 32'(lk_exp[f]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/usrt_tx_sched.md
Name: usrt_tx_sched

Overview:
- Round-robin scheduler that shares one txshift serializer between N byte requesters.
- Arbitrates among requesters and latches the winner's byte and the baud divisor.
- Launches the frame with a single-cycle enable, waits for the shifter's Pready pulse, then acks the requester.
- Sits between the USRT host-side register/FIFO requesters and the txshift instance.

Parameters:
N_REQ, 4, number of requesters (2..8)
DRAIN_CYC, 12, post-reset cycles held at baud=1 to flush a shifter frame left in flight

Ports:
i_Pclk  in  1  clock, all logic on rising edge
i_Presetn  in  1  asynchronous active-low reset
i_Req  in  N_REQ  per-requester level request
i_Data  in  8*N_REQ  requester bytes, requester k at [8k+7:8k]
i_Lock  in  N_REQ  per-requester grant lock (used only with USRT_TXSCHED_LOCK_EN)
i_Baud  in  8  clocks per bit, sampled at grant
o_Grant  out  N_REQ  one-hot owner of the current frame, 0 when none
o_Ack  out  N_REQ  one-cycle pulse: requester's byte fully sent
o_Busy  out  1  high in every state except IDLE
o_Tx_Enable  out  1  to shifter enable, one-cycle pulse
o_Tx_Data  out  8  to shifter data, held stable for the whole frame
o_Tx_Baud  out  8  to shifter baud, held stable for the whole frame
i_Tx_Pready  in  1  from shifter, one-cycle frame-done pulse

Behaviour:
- Reset values: o_Grant=0, o_Ack=0, o_Tx_Enable=0, o_Tx_Data=0, o_Tx_Baud=8'd1, o_Busy=1.
- Reset: state=DRAIN, drain counter=0, round-robin pointer=0.
- All outputs are registered.
- FSM states: DRAIN, IDLE, LAUNCH, WAIT, GAP.
- DRAIN:
  - Holds o_Tx_Baud=1 and o_Tx_Enable=0 for DRAIN_CYC cycles, then goes to IDLE.
  - At baud=1 any shifter frame in flight ends within 11 cycles; i_Tx_Pready is ignored here.
- IDLE:
  - o_Busy=0.
  - If i_Req is nonzero, the winner is the first set bit at or after the pointer, searching upward with wrap.
  - On a win, in the same edge: o_Grant=onehot(winner), o_Tx_Data=winner's byte, o_Tx_Baud=(i_Baud==0 ? 1 : i_Baud), o_Tx_Enable=1, next state LAUNCH.
  - Baud 0 is substituted with 1 because the shifter would count forever on 0.
- LAUNCH:
  - o_Tx_Enable=1 for exactly this cycle.
  - Next edge: o_Tx_Enable=0, state WAIT.
- WAIT:
  - On i_Tx_Pready=1: o_Ack=o_Grant for one cycle, o_Grant=0, pointer=(winner+1) mod N_REQ, state GAP.
- GAP: o_Ack returns to 0, state IDLE.
- The GAP+IDLE sequence guarantees the next enable lands with the shifter in its idle state.
- Latency:
  - Request sampled at edge E → o_Tx_Enable high in cycle E..E+1.
  - o_Ack high the cycle after the Pready cycle.
  - Minimum spacing from Pready to the next o_Tx_Enable is 3 cycles.
- Requester rules:
  - Requester may change i_Data or drop i_Req any time after grant; latched values are used.
  - Dropping i_Req mid-frame does not abort the frame, and the ack is still issued.
  - Requester updates data or drops the request on the ack cycle. A request still high in IDLE is a new frame.
- Pready outside WAIT is ignored.
- Changes on i_Baud mid-frame are ignored.
- Reset asserted mid-frame: all outputs go to reset values immediately, no ack is issued, and the FSM re-enters DRAIN.

Optional Feature:
- Macro USRT_TXSCHED_LOCK_EN.
- Defined:
  - In GAP, if the finishing winner has i_Lock=1 and i_Req=1, the pointer is not advanced; it is set to the winner instead.
  - This gives the same requester back-to-back frames.
  - Lock is released when i_Lock or i_Req is low at GAP.
- Undefined: i_Lock is ignored and the pointer always advances, so arbitration is strict round-robin.

Test Plan:
- Reset, no requests → o_Tx_Baud=1 for 12 cycles, then IDLE with o_Busy=0. No enable issued.
- i_Req=4'b0001, byte 8'hA5, i_Baud=4:
  - One o_Tx_Enable pulse.
  - Serial line on the shifter model shows 0,1,0,1,0,0,1,0,1,1 (LSB first), each bit 4 clocks.
  - o_Ack[0] pulses once.
- i_Req=4'b1011 held, bytes 11/22/33/44, baud 2:
  - Grant order 0,1,3,0,1,3.
  - Exactly one ack per frame.
  - Pready-to-next-enable gap ≥3 cycles.
- i_Baud=0 with a request → o_Tx_Baud=1; frame completes and is acked.
- i_Presetn low during DATA bits of a baud=8 frame → outputs reset, no ack. After DRAIN, a new request sends a correct frame.
- With USRT_TXSCHED_LOCK_EN, i_Req=4'b0011, i_Lock=4'b0001 → requester 0 gets 3 consecutive frames. Lock dropped → requester 1 is granted next.
